matrix_loader: RTL and testbench
================================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 5, number of matrix slots in storage.
REQ-002 SHALL have parameter SLOT_WORDS, default 32, words reserved per slot; NUM_SLOTS*SLOT_WORDS <= 256.
REQ-003 SHALL have parameter MAX_DIM, default 5, maximum rows and cols.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to load a new matrix.
REQ-007 SHALL have ports in_valid  input  1, in_ready  output  1, in_data  input  32: element stream.
REQ-008 SHALL have ports w_storage_we  output  1, w_storage_addr  output  8, w_storage_data  output  32: storage write port.
REQ-009 SHALL have ports done  output  1 (pulse), done_slot  output  3, err  output  1 (pulse).
REQ-010 SHALL have ports q_slot  input  3, q_valid  output  1, q_rows  output  3, q_cols  output  3: combinational dimension-table query.

Function
REQ-011 SHALL implement states IDLE, HDR_R, HDR_C, DATA, PAD, DONE, ERR.
REQ-012 IDLE -> HDR_R on start; start ignored in all other states.
REQ-013 Handshake: word accepted when in_valid && in_ready; in_ready = 1 only in HDR_R, HDR_C, DATA.
REQ-014 HDR_R accepts rows; HDR_C accepts cols; value 0 or > MAX_DIM -> ERR, else HDR_C -> DATA.
REQ-015 Target slot = write pointer wp; base = wp*SLOT_WORDS; element k written at base+k, row-major.
REQ-016 Each DATA acceptance SHALL drive w_storage_we=1, addr, data on the following cycle (1-cycle registered latency); we=0 otherwise.
REQ-017 After rows*cols elements accepted: -> PAD if LOADER_ZERO_PAD_EN defined, else -> DONE.
REQ-018 DONE: one-cycle done=1, done_slot=wp; table[wp] = {valid, rows, cols}; wp advances mod NUM_SLOTS; -> IDLE.
REQ-019 Slot full/wrap: when all slots valid, next load overwrites slot wp (oldest); its valid bit cleared on entry to DATA.
REQ-020 ERR: one-cycle err=1, no storage write, wp and table unchanged; -> IDLE.
REQ-021 Back-to-back: in_valid held high SHALL sustain one acceptance per cycle in DATA.
REQ-022 q_valid/q_rows/q_cols SHALL reflect table[q_slot] combinationally; q_slot >= NUM_SLOTS -> all zero.

Reset
REQ-023 rst_n low at a clock edge SHALL force IDLE, wp=0, all table entries invalid, in_ready=0, we=0, done=0, err=0, done_slot=0, addr=0, data=0.
REQ-024 Reset mid-load SHALL discard the partial matrix; no table entry marked valid.

Configuration
REQ-025 Macro LOADER_ZERO_PAD_EN: defined -> PAD state writes 0 to base+rows*cols .. base+SLOT_WORDS-1, one word per cycle, in_ready=0, then DONE.
REQ-026 Undefined -> PAD state absent; DATA -> DONE directly; unused slot words untouched.

Structure
REQ-027 Shared package SHALL hold the state enum, MAX_DIM, NUM_SLOTS, SLOT_WORDS, and the slot-entry struct {valid, rows, cols}.
REQ-028 One sub-module matrix_dim_table SHALL hold the NUM_SLOTS-entry table with write port and combinational query port.

Verification
REQ-029 Reset, start, send 2,3 then 1..6 -> writes addr 0..5 data 1..6, done with done_slot=0, q_slot=0 gives rows=2 cols=3 valid=1.
REQ-030 Send rows=6 -> err pulse, no we, wp stays 0, q_valid(0)=0.
REQ-031 Six consecutive 1x1 loads -> slots 0,1,2,3,4,0; sixth writes addr 0 and keeps slot 0 valid with new dims.
REQ-032 Pull rst_n low after 3 of 6 elements -> all outputs reset values, q_valid=0 for every slot.
REQ-033 With LOADER_ZERO_PAD_EN, 2x2 load into slot 1 -> data at 32..35, zeros at 36..63, then done.
REQ-034 in_valid toggled every other cycle during DATA -> writes only on accepted words, addresses contiguous, no gaps.

Source files
------------

// File: rtl/matrix_loader_pkg.sv
// Shared definitions for the matrix loader: FSM state encoding, default
// geometry of the slot storage and the dimension-table entry layout.
package matrix_loader_pkg;

  // Default geometry; the top-level parameters take these as defaults.
  localparam int MAX_DIM    = 5;
  localparam int NUM_SLOTS  = 5;
  localparam int SLOT_WORDS = 32;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DIM_W  = 3;
  localparam int SLOT_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR_R = 3'd1,
    HDR_C = 3'd2,
    DATA  = 3'd3,
    PAD   = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [DIM_W-1:0] rows;
    logic [DIM_W-1:0] cols;
  } slot_entry_t;

  // A header word is a usable dimension when it lies in 1..max_dim.
  function automatic logic dim_ok(input logic [DATA_W-1:0] v, input int unsigned max_dim);
    return (v != '0) && (v <= DATA_W'(max_dim));
  endfunction

endpackage

// File: rtl/matrix_dim_table.sv
// Per-slot dimension table: one registered entry {valid, rows, cols} per
// storage slot, a single write port and a combinational query port.
// Queries beyond the last slot read back as all zero.
module matrix_dim_table
  import matrix_loader_pkg::*;
#(
  parameter int NUM_ENTRIES = NUM_SLOTS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [SLOT_W-1:0] wr_idx_i,
  input  slot_entry_t       wr_entry_i,
  input  logic [SLOT_W-1:0] q_slot_i,
  output slot_entry_t       q_entry_o
);

  slot_entry_t tbl_q [NUM_ENTRIES];

  // Table storage: cleared by reset, one entry updated per write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (wr_idx_i == SLOT_W'(i)) begin
          tbl_q[i] <= wr_entry_i;
        end
      end
    end
  end

  // Query read: decoded mux so out-of-range slots fall through to zero.
  always_comb begin
    q_entry_o = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (q_slot_i == SLOT_W'(i)) begin
        q_entry_o = tbl_q[i];
      end
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Matrix loader: receives a header (rows, cols) and a row-major element
// stream, writes the elements into a fixed-size slot of external storage
// and records the dimensions in a per-slot table. Slots are used round
// robin; once all are full the oldest slot is overwritten.
//
// Optional feature: define LOADER_ZERO_PAD_EN to zero-fill the unused tail
// of the slot (PAD state) before signalling done. Without it the PAD state
// is never entered and the slot tail is left untouched.
//
// state | meaning
// IDLE  | waiting for start
// HDR_R | accepting the row count
// HDR_C | accepting the column count
// DATA  | accepting rows*cols elements, one storage write per element
// PAD   | zero-filling the slot tail (LOADER_ZERO_PAD_EN only)
// DONE  | one-cycle done pulse, table entry committed, write pointer advanced
// ERR   | one-cycle err pulse for an out-of-range dimension
module matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter int NUM_SLOTS  = matrix_loader_pkg::NUM_SLOTS,
  parameter int SLOT_WORDS = matrix_loader_pkg::SLOT_WORDS,
  parameter int MAX_DIM    = matrix_loader_pkg::MAX_DIM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              w_storage_we,
  output logic [ADDR_W-1:0] w_storage_addr,
  output logic [DATA_W-1:0] w_storage_data,
  output logic              done,
  output logic [SLOT_W-1:0] done_slot,
  output logic              err,
  input  logic [SLOT_W-1:0] q_slot,
  output logic              q_valid,
  output logic [DIM_W-1:0]  q_rows,
  output logic [DIM_W-1:0]  q_cols
);

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   wp_q, wp_d;
  logic [DIM_W-1:0]    rows_q, rows_d;
  logic [DIM_W-1:0]    cols_q, cols_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                tbl_we;
  slot_entry_t         tbl_entry;
  slot_entry_t         q_entry;

  logic [ADDR_W-1:0]   base;
  logic [ADDR_W-1:0]   total;
  logic [ADDR_W-1:0]   idx_next;
  logic                accept;

  // Slot base address and element count; both fit in 8 bits by construction.
  assign base     = ADDR_W'(wp_q * SLOT_WORDS);
  assign total    = {{(ADDR_W-DIM_W){1'b0}}, rows_q} * {{(ADDR_W-DIM_W){1'b0}}, cols_q};
  assign idx_next = idx_q + ADDR_W'(1);

  assign in_ready = (state_q == HDR_R) || (state_q == HDR_C) || (state_q == DATA);
  assign accept   = in_valid && in_ready;

  // done/err are pure state decodes, so each lasts exactly one cycle.
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign done_slot = done ? wp_q : '0;

  assign w_storage_we   = we_q;
  assign w_storage_addr = addr_q;
  assign w_storage_data = data_q;

  // Next-state, storage-write and table-update logic.
  always_comb begin
    state_d   = state_q;
    wp_d      = wp_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    idx_d     = idx_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    tbl_we    = 1'b0;
    tbl_entry = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HDR_R;
          idx_d   = '0;
        end
      end

      HDR_R: begin
        if (accept) begin
          if (dim_ok(in_data, MAX_DIM)) begin
            rows_d  = in_data[DIM_W-1:0];
            state_d = HDR_C;
          end else begin
            state_d = ERR;
          end
        end
      end

      HDR_C: begin
        if (accept) begin
          if (dim_ok(in_data, MAX_DIM)) begin
            cols_d  = in_data[DIM_W-1:0];
            idx_d   = '0;
            state_d = DATA;
            // The slot is about to be overwritten: drop its old entry now so a
            // half-written slot is never reported as valid.
            tbl_we    = 1'b1;
            tbl_entry = '0;
          end else begin
            state_d = ERR;
          end
        end
      end

      DATA: begin
        if (accept) begin
          we_d   = 1'b1;
          addr_d = base + idx_q;
          data_d = in_data;
          idx_d  = idx_next;
          if (idx_next == total) begin
`ifdef LOADER_ZERO_PAD_EN
            state_d = (idx_next == ADDR_W'(SLOT_WORDS)) ? DONE : PAD;
`else
            state_d = DONE;
`endif
          end
        end
      end

      PAD: begin
`ifdef LOADER_ZERO_PAD_EN
        we_d   = 1'b1;
        addr_d = base + idx_q;
        data_d = '0;
        idx_d  = idx_next;
        if (idx_next == ADDR_W'(SLOT_WORDS)) begin
          state_d = DONE;
        end
`else
        state_d = IDLE;
`endif
      end

      DONE: begin
        tbl_we          = 1'b1;
        tbl_entry.valid = 1'b1;
        tbl_entry.rows  = rows_q;
        tbl_entry.cols  = cols_q;
        wp_d    = (wp_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : wp_q + SLOT_W'(1);
        state_d = IDLE;
      end

      ERR: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered storage-write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  matrix_dim_table #(
    .NUM_ENTRIES (NUM_SLOTS)
  ) u_dim_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (tbl_we),
    .wr_idx_i   (wp_q),
    .wr_entry_i (tbl_entry),
    .q_slot_i   (q_slot),
    .q_entry_o  (q_entry)
  );

  assign q_valid = q_entry.valid;
  assign q_rows  = q_entry.rows;
  assign q_cols  = q_entry.cols;

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader. Stimulus tasks push the expected
// storage writes and done/err events into queues; a negedge monitor pops
// and compares whatever the DUT emits. A slot-level model (write pointer
// plus per-slot dims) predicts addresses and the dimension table.
module tb_matrix_loader;

  localparam int NS = 5;
  localparam int SW = 32;
  localparam int MD = 5;
  localparam int EV_ERR = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        w_storage_we;
  logic [7:0]  w_storage_addr;
  logic [31:0] w_storage_data;
  logic        done;
  logic [2:0]  done_slot;
  logic        err;
  logic [2:0]  q_slot;
  logic        q_valid;
  logic [2:0]  q_rows;
  logic [2:0]  q_cols;

  int checks = 0;
  int errors = 0;

  logic [39:0] exp_wr[$];
  int          exp_ev[$];

  int m_wp;
  bit m_valid[NS];
  int m_rows[NS];
  int m_cols[NS];

  always #5 clk = ~clk;

  matrix_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .w_storage_we   (w_storage_we),
    .w_storage_addr (w_storage_addr),
    .w_storage_data (w_storage_data),
    .done           (done),
    .done_slot      (done_slot),
    .err            (err),
    .q_slot         (q_slot),
    .q_valid        (q_valid),
    .q_rows         (q_rows),
    .q_cols         (q_cols)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write and every done/err pulse must match the next expectation.
  always @(negedge clk) begin
    logic [39:0] e;
    int ev;
    if (w_storage_we) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", w_storage_addr, w_storage_data);
      end else begin
        e = exp_wr.pop_front();
        chk("write_addr", w_storage_addr, e[39:32]);
        chk("write_data", w_storage_data, e[31:0]);
      end
    end
    if (done || err) begin
      ev = (done && err) ? 200 : (done ? int'(done_slot) : EV_ERR);
      if (exp_ev.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %0d, expected none", ev);
      end else begin
        chk("event", ev, exp_ev.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_wp = 0;
    for (int s = 0; s < NS; s++) begin
      m_valid[s] = 1'b0;
      m_rows[s]  = 0;
      m_cols[s]  = 0;
    end
  endtask

  task automatic check_table();
    for (int s = 0; s < 8; s++) begin
      q_slot = 3'(s);
      #1;
      if (s < NS) begin
        chk($sformatf("q_valid[%0d]", s), q_valid, m_valid[s]);
        if (m_valid[s]) begin
          chk($sformatf("q_rows[%0d]", s), q_rows, m_rows[s]);
          chk($sformatf("q_cols[%0d]", s), q_cols, m_cols[s]);
        end
      end else begin
        chk($sformatf("q_oob[%0d]", s), {q_valid, q_rows, q_cols}, 0);
      end
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_we", w_storage_we, 0);
    chk("rst_addr", w_storage_addr, 0);
    chk("rst_data", w_storage_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_done_slot", done_slot, 0);
    chk("rst_in_ready", in_ready, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    repeat (2) step();
    model_clear();
    exp_wr.delete();
    exp_ev.delete();
    check_reset_outputs();
    check_table();
    rst_n = 1'b1;
    step();
  endtask

  // Present one word, holding in_valid until it is accepted.
  task automatic send_word(input logic [31:0] d, input int gap);
    int  n;
    bit  acc;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) step();
    end
    in_valid = 1'b1;
    in_data  = d;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: word %0h not accepted within 50 cycles", d);
    end
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while ((exp_wr.size() != 0 || exp_ev.size() != 0) && n < 200) begin
      step();
      n++;
    end
    if (exp_wr.size() != 0 || exp_ev.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d writes and %0d events still pending", exp_wr.size(), exp_ev.size());
      exp_wr.delete();
      exp_ev.delete();
    end
  endtask

  // One complete load. gap_mode: 0 back-to-back, 1 random gaps, 2 alternating.
  task automatic load(input int r, input int c, input int gap_mode, input bit seq_data, input bit start_noise);
    int slot;
    int n;
    int gap;
    logic [31:0] d;
    logic [31:0] vals[$];
    start = 1'b1;
    step();
    start = 1'b0;
    if (r == 0 || r > MD) begin
      exp_ev.push_back(EV_ERR);
      send_word(32'(r), 0);
      drain();
      return;
    end
    send_word(32'(r), 0);
    if (c == 0 || c > MD) begin
      exp_ev.push_back(EV_ERR);
      send_word(32'(c), 0);
      drain();
      return;
    end
    slot = m_wp;
    n = r * c;
    for (int k = 0; k < n; k++) begin
      d = seq_data ? 32'(k + 1) : $urandom();
      vals.push_back(d);
      exp_wr.push_back({8'(slot * SW + k), d});
    end
`ifdef LOADER_ZERO_PAD_EN
    for (int k = n; k < SW; k++) begin
      exp_wr.push_back({8'(slot * SW + k), 32'd0});
    end
`endif
    exp_ev.push_back(slot);
    send_word(32'(c), 0);
    for (int k = 0; k < n; k++) begin
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? int'($urandom_range(0, 1)) : ((k > 0) ? 1 : 0);
      if (start_noise && k == 1) start = 1'b1;
      send_word(vals[k], gap);
      start = 1'b0;
    end
    drain();
    m_valid[slot] = 1'b1;
    m_rows[slot]  = r;
    m_cols[slot]  = c;
    m_wp = (m_wp + 1) % NS;
  endtask

  initial begin
    int r;
    int c;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    q_slot   = '0;
    rst_n    = 1'b0;

    do_reset();

    // Bad row count: err only, nothing written, slot 0 stays invalid.
    load(6, 1, 0, 1'b0, 1'b0);
    check_table();

    // 2x3 into slot 0 with data 1..6 (also proves wp stayed at 0).
    load(2, 3, 0, 1'b1, 1'b0);
    check_table();

    // Bad column count after a good row count.
    load(3, 0, 0, 1'b0, 1'b0);
    check_table();

    // Six 1x1 loads wrap around and overwrite slot 0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      load(1, 1, 0, 1'b0, i == 3);
      check_table();
    end

    // Alternating in_valid during DATA.
    load(3, 2, 2, 1'b0, 1'b0);
    check_table();

    // Randomized loads, including out-of-range headers.
    for (int i = 0; i < 12; i++) begin
      r = ($urandom_range(0, 3) != 0) ? int'($urandom_range(1, MD)) : int'($urandom_range(0, 7));
      c = ($urandom_range(0, 3) != 0) ? int'($urandom_range(1, MD)) : int'($urandom_range(0, 7));
      load(r, c, 1, 1'b0, i[0]);
      check_table();
    end

    // Reset after 3 of 6 elements of a 2x3 load.
    start = 1'b1;
    step();
    start = 1'b0;
    send_word(32'd2, 0);
    for (int k = 0; k < 3; k++) begin
      exp_wr.push_back({8'(m_wp * SW + k), 32'(k + 10)});
    end
    send_word(32'd3, 0);
    for (int k = 0; k < 3; k++) begin
      send_word(32'(k + 10), 0);
    end
    in_valid = 1'b0;
    repeat (2) step();
    chk("pre_reset_writes_seen", exp_wr.size(), 0);
    do_reset();

    // After reset the next load lands in slot 0 again.
    load(1, 2, 1, 1'b0, 1'b0);
    check_table();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
